// File: rtl/stage2_decode.sv
// Decode stage: IF/ID register, 8x16 register file with write-through,
// load-use hazard detection and the ID/EX register feeding execute.
module stage2_decode #(
  parameter int PC_W = 12,
  parameter int IW   = 16,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pcIn,
  input  logic [IW-1:0]   instrIn,
  input  logic            flush,
  input  logic            exMemRead,
  input  logic [2:0]      exRd,
  input  logic            wbWrite,
  input  logic [2:0]      wbRd,
  input  logic [DW-1:0]   wbData,
  output logic            pcHold,
  output logic            idexValid,
  output logic [PC_W-1:0] idexPc,
  output logic [3:0]      idexOp,
  output logic [2:0]      idexRd,
  output logic [DW-1:0]   idexA,
  output logic [DW-1:0]   idexB,
  output logic [DW-1:0]   idexImm
);

  logic            ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [IW-1:0]   ifid_instr_q, ifid_instr_d;

  logic [DW-1:0]   rf_q [8];
  logic [DW-1:0]   rf_d [8];

  logic            idex_valid_q, idex_valid_d;
  logic [PC_W-1:0] idex_pc_q, idex_pc_d;
  logic [3:0]      idex_op_q, idex_op_d;
  logic [2:0]      idex_rd_q, idex_rd_d;
  logic [DW-1:0]   idex_a_q, idex_a_d;
  logic [DW-1:0]   idex_b_q, idex_b_d;
  logic [DW-1:0]   idex_imm_q, idex_imm_d;

  logic [2:0]      rs, rt;
  logic [DW-1:0]   rs_data, rt_data;
  logic            hold;

  assign rs = ifid_instr_q[11:9];
  assign rt = ifid_instr_q[8:6];

  // A writeback landing this cycle is forwarded so ID/EX never sees a stale value.
  always_comb begin
    rs_data = rf_q[rs];
    rt_data = rf_q[rt];
    if (wbWrite && (wbRd == rs)) rs_data = wbData;
    if (wbWrite && (wbRd == rt)) rt_data = wbData;
  end

  always_comb begin
    hold = ifid_valid_q & exMemRead & idex_valid_q & ((exRd == rs) | (exRd == rt));
  end

  always_comb begin
    ifid_valid_d = 1'b1;
    ifid_pc_d    = pcIn;
    ifid_instr_d = instrIn;
    if (flush) begin
      ifid_valid_d = 1'b0;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = '0;
    end else if (hold) begin
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
    end
  end

  always_comb begin
    idex_valid_d = 1'b0;
    idex_pc_d    = '0;
    idex_op_d    = '0;
    idex_rd_d    = '0;
    idex_a_d     = '0;
    idex_b_d     = '0;
    idex_imm_d   = '0;
    if (ifid_valid_q && !hold) begin
      idex_valid_d = 1'b1;
      idex_pc_d    = ifid_pc_q;
      idex_op_d    = ifid_instr_q[15:12];
      idex_rd_d    = ifid_instr_q[5:3];
      idex_a_d     = rs_data;
      idex_b_d     = rt_data;
      idex_imm_d   = {{(DW-6){ifid_instr_q[5]}}, ifid_instr_q[5:0]};
    end
  end

  // r0 is an ordinary register here, so every index is writable.
  always_comb begin
    for (int i = 0; i < 8; i++) rf_d[i] = rf_q[i];
    if (wbWrite) rf_d[wbRd] = wbData;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      idex_valid_q <= 1'b0;
      idex_pc_q    <= '0;
      idex_op_q    <= '0;
      idex_rd_q    <= '0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      idex_imm_q   <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      idex_valid_q <= idex_valid_d;
      idex_pc_q    <= idex_pc_d;
      idex_op_q    <= idex_op_d;
      idex_rd_q    <= idex_rd_d;
      idex_a_q     <= idex_a_d;
      idex_b_q     <= idex_b_d;
      idex_imm_q   <= idex_imm_d;
      for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign pcHold    = hold;
  assign idexValid = idex_valid_q;
  assign idexPc    = idex_pc_q;
  assign idexOp    = idex_op_q;
  assign idexRd    = idex_rd_q;
  assign idexA     = idex_a_q;
  assign idexB     = idex_b_q;
  assign idexImm   = idex_imm_q;

endmodule

// File: tb/tb_stage2_decode.sv
// Self-checking bench for stage2_decode: directed pipeline scenarios followed
// by random traffic, all compared against a cycle-level behavioural model.
module tb_stage2_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pcIn;
  logic [15:0] instrIn;
  logic        flush;
  logic        exMemRead;
  logic [2:0]  exRd;
  logic        wbWrite;
  logic [2:0]  wbRd;
  logic [15:0] wbData;
  logic        pcHold;
  logic        idexValid;
  logic [11:0] idexPc;
  logic [3:0]  idexOp;
  logic [2:0]  idexRd;
  logic [15:0] idexA;
  logic [15:0] idexB;
  logic [15:0] idexImm;

  stage2_decode dut (
    .clk(clk), .rst(rst), .pcIn(pcIn), .instrIn(instrIn), .flush(flush),
    .exMemRead(exMemRead), .exRd(exRd), .wbWrite(wbWrite), .wbRd(wbRd),
    .wbData(wbData), .pcHold(pcHold), .idexValid(idexValid), .idexPc(idexPc),
    .idexOp(idexOp), .idexRd(idexRd), .idexA(idexA), .idexB(idexB),
    .idexImm(idexImm)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;
  logic last_hold;

  // Reference state: what the decode stage should hold, in architectural terms.
  logic [15:0] m_regs [8];
  logic        m_if_valid;
  logic [11:0] m_if_pc;
  logic [15:0] m_if_instr;
  logic        m_ex_valid;
  logic [11:0] m_ex_pc;
  logic [3:0]  m_ex_op;
  logic [2:0]  m_ex_rd;
  logic [15:0] m_ex_a, m_ex_b, m_ex_imm;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sext6(input logic [15:0] instr);
    int v;
    v = int'(instr) % 64;
    if (v >= 32) v = v - 64;
    return 16'(v);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_if_valid = 0; m_if_pc = 0; m_if_instr = 0;
    m_ex_valid = 0; m_ex_pc = 0; m_ex_op = 0; m_ex_rd = 0;
    m_ex_a = 0; m_ex_b = 0; m_ex_imm = 0;
  endtask

  // One clock cycle: drive inputs, check the hazard output mid-cycle,
  // advance the model across the edge, then check the ID/EX outputs.
  task automatic applyStimulus(input logic r, input logic [11:0] p, input logic [15:0] ins,
                               input logic fl, input logic mr, input logic [2:0] xr,
                               input logic ww, input logic [2:0] wr, input logic [15:0] wd);
    logic hold;
    int rs_i, rt_i;
    logic [15:0] a_v, b_v;
    rst = r; pcIn = p; instrIn = ins; flush = fl; exMemRead = mr; exRd = xr;
    wbWrite = ww; wbRd = wr; wbData = wd;
    rs_i = int'(m_if_instr) / 512 % 8;
    rt_i = int'(m_if_instr) / 64 % 8;
    hold = m_if_valid && mr && m_ex_valid && (int'(xr) == rs_i || int'(xr) == rt_i);
    @(negedge clk);
    checkOutput("pcHold", {31'd0, pcHold}, {31'd0, hold});
    last_hold = pcHold;
    @(posedge clk);
    if (!r) begin
      modelReset();
    end else begin
      a_v = (ww && int'(wr) == rs_i) ? wd : m_regs[rs_i];
      b_v = (ww && int'(wr) == rt_i) ? wd : m_regs[rt_i];
      if (hold || !m_if_valid) begin
        m_ex_valid = 0; m_ex_pc = 0; m_ex_op = 0; m_ex_rd = 0;
        m_ex_a = 0; m_ex_b = 0; m_ex_imm = 0;
      end else begin
        m_ex_valid = 1;
        m_ex_pc    = m_if_pc;
        m_ex_op    = 4'(int'(m_if_instr) / 4096);
        m_ex_rd    = 3'(int'(m_if_instr) / 8 % 8);
        m_ex_a     = a_v;
        m_ex_b     = b_v;
        m_ex_imm   = sext6(m_if_instr);
      end
      if (ww) m_regs[wr] = wd;
      if (fl) begin
        m_if_valid = 0; m_if_instr = 0;
      end else if (!hold) begin
        m_if_valid = 1; m_if_pc = p; m_if_instr = ins;
      end
    end
    #1;
    checkOutput("idexValid", {31'd0, idexValid}, {31'd0, m_ex_valid});
    checkOutput("idexPc", {20'd0, idexPc}, {20'd0, m_ex_pc});
    checkOutput("idexOp", {28'd0, idexOp}, {28'd0, m_ex_op});
    checkOutput("idexRd", {29'd0, idexRd}, {29'd0, m_ex_rd});
    checkOutput("idexA", {16'd0, idexA}, {16'd0, m_ex_a});
    checkOutput("idexB", {16'd0, idexB}, {16'd0, m_ex_b});
    checkOutput("idexImm", {16'd0, idexImm}, {16'd0, m_ex_imm});
  endtask

  initial begin
    logic [15:0] ins;
    logic [2:0]  xr;
    modelReset();
    rst = 0; pcIn = 0; instrIn = 0; flush = 0; exMemRead = 0; exRd = 0;
    wbWrite = 0; wbRd = 0; wbData = 0;

    // Reset, then first fetch: 1298 = op1 rs1 rt2 rd3 imm6 0x18 (positive).
    applyStimulus(0, 12'h000, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
    applyStimulus(0, 12'h000, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
    checkOutput("t1_reset_valid", {31'd0, idexValid}, 32'd0);
    applyStimulus(1, 12'h004, 16'h1298, 0, 0, 0, 0, 0, 16'h0);
    checkOutput("t1_latency", {31'd0, idexValid}, 32'd0);
    applyStimulus(1, 12'h004, 16'h1298, 0, 0, 0, 0, 0, 16'h0);
    checkOutput("t1_valid", {31'd0, idexValid}, 32'd1);
    checkOutput("t1_pc", {20'd0, idexPc}, 32'h004);
    checkOutput("t1_rd", {29'd0, idexRd}, 32'd3);
    checkOutput("t1_imm", {16'd0, idexImm}, 32'h0018);

    // Write-through into rs=1, then a plain read of r1.
    applyStimulus(1, 12'h004, 16'h1298, 0, 0, 0, 1, 1, 16'hBEEF);
    checkOutput("t2_fwd", {16'd0, idexA}, 32'hBEEF);
    applyStimulus(1, 12'h004, 16'h1298, 0, 0, 0, 0, 0, 16'h0);
    checkOutput("t2_read", {16'd0, idexA}, 32'hBEEF);

    // Load-use on rt=2: one stall cycle, one bubble, then issue.
    applyStimulus(1, 12'h008, 16'h2000, 0, 1, 2, 0, 0, 16'h0);
    checkOutput("t3_hold", {31'd0, last_hold}, 32'd1);
    checkOutput("t3_bubble", {31'd0, idexValid}, 32'd0);
    applyStimulus(1, 12'h008, 16'h2000, 0, 1, 2, 0, 0, 16'h0);
    checkOutput("t3_release", {31'd0, last_hold}, 32'd0);
    checkOutput("t3_issue", {31'd0, idexValid}, 32'd1);
    checkOutput("t3_issue_pc", {20'd0, idexPc}, 32'h004);

    // No false stall: exRd unrelated, then load flag clear.
    applyStimulus(1, 12'h00C, 16'h1298, 0, 0, 0, 0, 0, 16'h0);
    applyStimulus(1, 12'h00C, 16'h1298, 0, 1, 5, 0, 0, 16'h0);
    checkOutput("t4_caseA", {31'd0, last_hold}, 32'd0);
    applyStimulus(1, 12'h00C, 16'h1298, 0, 0, 1, 0, 0, 16'h0);
    checkOutput("t4_caseB", {31'd0, last_hold}, 32'd0);

    // Flush while the hazard is active.
    applyStimulus(1, 12'h010, 16'h1298, 1, 1, 1, 0, 0, 16'h0);
    checkOutput("t5_hold", {31'd0, last_hold}, 32'd1);
    applyStimulus(1, 12'h014, 16'h1298, 0, 1, 1, 0, 0, 16'h0);
    checkOutput("t5_nohold", {31'd0, last_hold}, 32'd0);
    checkOutput("t5_bubble", {31'd0, idexValid}, 32'd0);
    applyStimulus(1, 12'h018, 16'h1298, 0, 0, 0, 0, 0, 16'h0);
    checkOutput("t5_refill", {31'd0, idexValid}, 32'd1);

    // Reset asserted in the middle of a stall clears everything.
    applyStimulus(0, 12'h01C, 16'h1298, 0, 1, 1, 1, 3, 16'h1234);
    checkOutput("t6_hold", {31'd0, last_hold}, 32'd1);
    checkOutput("t6_valid", {31'd0, idexValid}, 32'd0);
    applyStimulus(1, 12'h020, 16'h1298, 0, 1, 1, 0, 0, 16'h0);
    checkOutput("t6_nohold", {31'd0, last_hold}, 32'd0);
    applyStimulus(1, 12'h020, 16'h1298, 0, 0, 0, 0, 0, 16'h0);
    checkOutput("t6_r1_zero", {16'd0, idexA}, 32'h0);

    // Random traffic, biased so load-use hazards and forwarding occur often.
    for (int i = 0; i < 600; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(1, 0) == 1)
        xr = ($urandom_range(1, 0) == 1) ? m_if_instr[11:9] : m_if_instr[8:6];
      else
        xr = 3'($urandom);
      applyStimulus(($urandom_range(31, 0) != 0), 12'($urandom), ins,
                    ($urandom_range(9, 0) == 0), 1'($urandom), xr,
                    1'($urandom), 3'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
